dmem_ctrl: RTL and testbench

- Parametrised data memory for the MIPS datapath with a valid/ready request port and a registered response port.
- Supports byte, halfword and word loads and stores, big-endian layout, and signed or unsigned load extension.
- Detects misaligned and illegal accesses and has a configurable fixed read latency.
- Sits between the MEM stage and the byte-array store; the MEM stage stalls on w_req_ready/w_resp_valid.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_load_align.sv | 36 +++
 rtl/dmem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - Access size encodings (byte / half / word / reserved).
//   - Controller state enumeration.
//   - size_bytes(): number of bytes touched by an access of a given size.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Reserved size reports zero bytes; callers treat it as an error anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load-lane selection and extension.
// Takes the four bytes of an aligned 32-bit row (big-endian: raw[31:24] is
// the byte at offset 0) and returns the right-justified, sign- or
// zero-extended load result.
//   raw      in  32  row bytes, offset 0 in the most significant lane
//   size     in  2   access size encoding
//   zero_ext in  1   1 = zero-extend, 0 = sign-extend (byte/half only)
//   offset   in  2   byte offset of the access inside the row
//   data     out 32  extended load data (0 for the reserved size)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // ~offset == 3 - offset, so this picks the big-endian lane.
        byte_sel = raw[{~offset, 3'b000} +: 8];
        half_sel = offset[1] ? raw[15:0] : raw[31:16];
        data     = '0;
        case (size)
            SIZE_BYTE: data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = {{16{~zero_ext & half_sel[15]}}, half_sel};
            SIZE_WORD: data = raw;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable big-endian data memory with a valid/ready
// request port and a single-cycle response pulse after a fixed latency.
//   clock          in  1       rising-edge clock
//   reset_n        in  1       synchronous active-low reset
//   w_req_valid    in  1       request present
//   w_req_ready    out 1       request accepted on this edge if valid
//   w_req_write    in  1       1 = store, 0 = load
//   w_req_size     in  2       00 byte, 01 half, 10 word, 11 reserved
//   w_req_unsigned in  1       loads: 1 = zero-extend, 0 = sign-extend
//   w_req_addr     in  ADDR_W  byte address
//   w_req_wdata    in  32      store data, right-justified
//   w_resp_valid   out 1       one-cycle response pulse
//   w_resp_rdata   out 32      load data; 0 for stores and errors
//   w_resp_err     out 1       access rejected (misaligned / reserved size)
// Build option: define DMEM_CTRL_BOUNDS_CHECK_EN to reject accesses that run
// past MEM_BYTES instead of wrapping the address.
// Storage is four byte-wide banks (one per lane); every legal access is
// aligned, so it touches a single row across the banks.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic              w_req_write,
    input  logic [1:0]        w_req_size,
    input  logic              w_req_unsigned,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [31:0]       w_req_wdata,
    output logic              w_resp_valid,
    output logic [31:0]       w_resp_rdata,
    output logic              w_resp_err
);

    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam int ROW_W = IDX_W - 2;
    localparam int ROWS  = MEM_BYTES / 4;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             write_reg;
    logic [1:0]       size_reg;
    logic             zero_ext_reg;
    logic [1:0]       offset_reg;
    logic [ROW_W-1:0] row_reg;
    logic             err_reg;
    logic             resp_valid_reg;
    logic             resp_err_reg;
    logic             resp_load_reg;

    logic             accept;
    logic             req_err;
    logic             enter_resp;
    logic             resp_err_next;
    logic             resp_load_next;
    logic [ROW_W-1:0] req_row;
    logic [ROW_W-1:0] rd_row;
    logic [31:0]      raw_q;
    logic [31:0]      aligned;

    assign w_req_ready = reset_n && (state_reg != WAIT);
    assign accept      = w_req_valid && w_req_ready;
    assign req_row     = w_req_addr[IDX_W-1:2];

`ifdef DMEM_CTRL_BOUNDS_CHECK_EN
    // One extra bit so an address near the top of the space cannot wrap.
    logic [ADDR_W:0] last_addr;
    assign last_addr = {1'b0, w_req_addr} + (ADDR_W+1)'(size_bytes(w_req_size))
                       - (ADDR_W+1)'(1);
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^w_req_addr[ADDR_W-1:IDX_W];
`endif

    always_comb begin
        req_err = 1'b0;
        case (w_req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = w_req_addr[0];
            SIZE_WORD: req_err = |w_req_addr[1:0];
            default:   req_err = 1'b1;
        endcase
`ifdef DMEM_CTRL_BOUNDS_CHECK_EN
        if (last_addr >= (ADDR_W+1)'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
`endif
    end

    // With LATENCY==1 the response state is entered on the accept edge itself,
    // so the read and the response flags come straight from the request.
    assign enter_resp     = (LATENCY == 1) ? accept
                                           : (state_reg == WAIT && cnt_reg == CNT_W'(1));
    assign rd_row         = (LATENCY == 1) ? req_row : row_reg;
    assign resp_err_next  = (LATENCY == 1) ? req_err : err_reg;
    assign resp_load_next = (LATENCY == 1) ? (!w_req_write && !req_err)
                                           : (!write_reg && !err_reg);

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        localparam logic [1:0] LANE = 2'(gi);
        localparam int         SH   = 8 * (3 - gi);

        logic [7:0] bank [ROWS];
        logic [7:0] q_reg;
        logic       lane_hit;
        logic       we;
        logic [7:0] wbyte;

        always_comb begin
            lane_hit = 1'b0;
            wbyte    = w_req_wdata[7:0];
            case (w_req_size)
                SIZE_BYTE: lane_hit = (w_req_addr[1:0] == LANE);
                SIZE_HALF: begin
                    lane_hit = (w_req_addr[1] == LANE[1]);
                    wbyte    = LANE[0] ? w_req_wdata[7:0] : w_req_wdata[15:8];
                end
                SIZE_WORD: begin
                    lane_hit = 1'b1;
                    wbyte    = w_req_wdata[SH +: 8];
                end
                default:   lane_hit = 1'b0;
            endcase
        end

        // Stores commit on the accepting edge; errored stores never write.
        assign we = accept && w_req_write && !req_err && lane_hit;

        always_ff @(posedge clock) begin
            if (we) begin
                bank[req_row] <= wbyte;
            end
            if (enter_resp) begin
                q_reg <= bank[rd_row];
            end
        end
    end

    assign raw_q = {g_bank[0].q_reg, g_bank[1].q_reg, g_bank[2].q_reg, g_bank[3].q_reg};

    dmem_load_align u_align (
        .raw      (raw_q),
        .size     (size_reg),
        .zero_ext (zero_ext_reg),
        .offset   (offset_reg),
        .data     (aligned)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            write_reg      <= 1'b0;
            size_reg       <= SIZE_BYTE;
            zero_ext_reg   <= 1'b0;
            offset_reg     <= '0;
            row_reg        <= '0;
            err_reg        <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_load_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_load_reg  <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        write_reg    <= w_req_write;
                        size_reg     <= w_req_size;
                        zero_ext_reg <= w_req_unsigned;
                        offset_reg   <= w_req_addr[1:0];
                        row_reg      <= req_row;
                        err_reg      <= req_err;
                        cnt_reg      <= CNT_W'(LATENCY - 1);
                        state_reg    <= (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RESP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (enter_resp) begin
                resp_valid_reg <= 1'b1;
                resp_err_reg   <= resp_err_next;
                resp_load_reg  <= resp_load_next;
            end
        end
    end

    assign w_resp_valid = resp_valid_reg;
    assign w_resp_err   = resp_err_reg;
    assign w_resp_rdata = resp_load_reg ? aligned : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (LATENCY 1, 3, 4) share one clock.
// A byte-array reference model per instance computes every expected value.
`timescale 1ns/1ps
module tb_dmem_ctrl;

    localparam int N    = 3;
    localparam int MEMB = 4096;

    logic        clk = 1'b0;
    logic        rst_n        [N];
    logic        req_valid    [N];
    logic        req_ready    [N];
    logic        req_write    [N];
    logic [1:0]  req_size     [N];
    logic        req_unsigned [N];
    logic [31:0] req_addr     [N];
    logic [31:0] req_wdata    [N];
    logic        resp_valid   [N];
    logic [31:0] resp_rdata   [N];
    logic        resp_err     [N];

    bit   [7:0]  model [N][MEMB];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int         cyc;
        bit         err;
        bit [31:0]  rd;
    } exp_t;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        dmem_ctrl #(
            .ADDR_W    (32),
            .MEM_BYTES (MEMB),
            .LATENCY   ((gi == 0) ? 1 : (gi == 1) ? 3 : 4)
        ) u_dut (
            .clock          (clk),
            .reset_n        (rst_n[gi]),
            .w_req_valid    (req_valid[gi]),
            .w_req_ready    (req_ready[gi]),
            .w_req_write    (req_write[gi]),
            .w_req_size     (req_size[gi]),
            .w_req_unsigned (req_unsigned[gi]),
            .w_req_addr     (req_addr[gi]),
            .w_req_wdata    (req_wdata[gi]),
            .w_resp_valid   (resp_valid[gi]),
            .w_resp_rdata   (resp_rdata[gi]),
            .w_resp_err     (resp_err[gi])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one access: big-endian bytes, alignment rules,
    // optional range check, extension of narrow loads.
    function automatic void model_access(input int d, input bit wr, input bit [1:0] sz,
                                         input bit uns, input bit [31:0] a, input bit [31:0] wd,
                                         output bit err, output bit [31:0] rd);
        int        n;
        longint    last;
        bit [31:0] v;
        bit [31:0] ones;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        err  = (n == 0) || ((a % n) != 0);
        last = longint'(a) + n - 1;
`ifdef DMEM_CTRL_BOUNDS_CHECK_EN
        if (last >= MEMB) err = 1'b1;
`endif
        rd = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < n; i++)
                model[d][(a + i) % MEMB] = 8'(wd >> (8 * (n - 1 - i)));
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | 32'(model[d][(a + i) % MEMB]);
            ones = 32'hFFFF_FFFF;
            if (!uns && n < 4 && v[8*n-1]) v = v | (ones << (8 * n));
            rd = v;
        end
    endfunction

    // One isolated request; caller is #1 past a rising edge.
    task automatic txn(input int d, input string tag, input bit wr, input bit [1:0] sz,
                       input bit uns, input bit [31:0] a, input bit [31:0] wd,
                       output logic [31:0] got);
        bit        e_err;
        bit [31:0] e_rd;
        int        n;
        req_write[d] = wr; req_size[d] = sz; req_unsigned[d] = uns;
        req_addr[d]  = a;  req_wdata[d] = wd; req_valid[d] = 1'b1;
        got = 32'd0;
        n = 0;
        while (!req_ready[d] && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        if (!req_ready[d]) begin req_valid[d] = 1'b0; return; end
        @(posedge clk);
        model_access(d, wr, sz, uns, a, wd, e_err, e_rd);
        #1;
        req_valid[d] = 1'b0;
        n = 0;
        while (!resp_valid[d] && n < lat_of(d) + 8) begin @(posedge clk); #1; n++; end
        check({tag, " lat"}, 32'(n), 32'(lat_of(d) - 1));
        check({tag, " err"}, 32'(resp_err[d]), 32'(e_err));
        check({tag, " rdata"}, resp_rdata[d], e_rd);
        got = resp_rdata[d];
        @(posedge clk); #1;
        check({tag, " pulse"}, 32'(resp_valid[d]), 32'd0);
    endtask

    task automatic rand_req(input int d, input bit allow_hi);
        int        r;
        bit [31:0] a;
        r = $urandom_range(0, 9);
        req_size[d]     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        req_write[d]    = ($urandom_range(0, 2) == 0);
        req_unsigned[d] = 1'($urandom_range(0, 1));
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
        if (allow_hi && $urandom_range(0, 3) == 0) a = a | (32'h1000 * 32'($urandom_range(1, 3)));
        req_addr[d]  = a;
        req_wdata[d] = $urandom;
    endtask

    // Valid held high across cnt requests; checks accept spacing and latency.
    task automatic stream(input int d, input int cnt, input bit allow_hi);
        exp_t      q[$];
        exp_t      e;
        int        cyc = 0;
        int        accepted = 0;
        int        last_acc = -1;
        bit        will_acc;
        bit        e_err;
        bit [31:0] e_rd;
        rand_req(d, allow_hi);
        req_valid[d] = 1'b1;
        while ((accepted < cnt || q.size() > 0) && cyc < 400) begin
            will_acc = req_valid[d] && req_ready[d];
            @(posedge clk);
            cyc++;
            if (will_acc) begin
                model_access(d, req_write[d], req_size[d], req_unsigned[d],
                             req_addr[d], req_wdata[d], e_err, e_rd);
                q.push_back('{cyc: cyc, err: e_err, rd: e_rd});
                if (last_acc >= 0) check("stream gap", 32'(cyc - last_acc), 32'(lat_of(d)));
                last_acc = cyc;
                accepted++;
            end
            #1;
            if (will_acc) begin
                if (accepted < cnt) rand_req(d, allow_hi);
                else req_valid[d] = 1'b0;
            end
            if (resp_valid[d]) begin
                if (q.size() == 0) begin
                    check("stream spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("stream lat", 32'(cyc - e.cyc), 32'(lat_of(d) - 1));
                    check("stream err", 32'(resp_err[d]), 32'(e.err));
                    check("stream rdata", resp_rdata[d], e.rd);
                end
            end
        end
        req_valid[d] = 1'b0;
        check("stream drained", 32'(q.size()), 32'd0);
        check("stream count", 32'(accepted), 32'(cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] got0;
        bit          seen;
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check("reset ready", 32'(req_ready[d]), 32'd0);
            check("reset valid", 32'(resp_valid[d]), 32'd0);
            check("reset err", 32'(resp_err[d]), 32'd0);
            check("reset rdata", resp_rdata[d], 32'd0);
            rst_n[d] = 1'b1;
        end
        @(posedge clk); #1;
        for (int d = 0; d < N; d++) check("post reset ready", 32'(req_ready[d]), 32'd1);

        // Known contents for the low 256 bytes of every instance.
        for (int d = 0; d < N; d++)
            for (int a = 0; a < 256; a += 4)
                txn(d, "prefill", 1'b1, 2'd2, 1'b0, 32'(a), $urandom, got);

        // Directed cases on the single-cycle instance.
        txn(0, "st word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        txn(0, "ld word", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        check("ld word const", got, 32'hDEADBEEF);
        txn(0, "ld byte s", 1'b0, 2'd0, 1'b0, 32'h10, 32'd0, got);
        check("ld byte s const", got, 32'hFFFFFFDE);
        txn(0, "ld byte u", 1'b0, 2'd0, 1'b1, 32'h10, 32'd0, got);
        check("ld byte u const", got, 32'h000000DE);
        txn(0, "st half", 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, got);
        txn(0, "ld half s", 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, got);
        check("ld half s const", got, 32'hFFFF8001);
        txn(0, "st byte", 1'b1, 2'd0, 1'b0, 32'h23, 32'h0000007F, got);
        txn(0, "ld word 20", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, got);
        check("ld word 20 low", {16'd0, got[15:0]}, 32'h0000807F);
        txn(0, "misal word", 1'b0, 2'd2, 1'b0, 32'h12, 32'd0, got);
        txn(0, "misal half st", 1'b1, 2'd1, 1'b0, 32'h13, 32'h0000AAAA, got);
        txn(0, "rsvd size", 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, got);
        txn(0, "ld after err", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        check("ld after err const", got, 32'hDEADBEEF);
        txn(0, "ld 0000", 1'b0, 2'd2, 1'b0, 32'h0000, 32'd0, got0);
        txn(0, "ld 1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, got);

        // Continuous valid: LATENCY 3, then mixed traffic on the other two.
        stream(1, 16, 1'b0);
        stream(0, 40, 1'b1);
        stream(2, 12, 1'b1);

        // Reset two cycles after a load is accepted on the LATENCY 4 instance.
        req_write[2] = 1'b0; req_size[2] = 2'd2; req_unsigned[2] = 1'b0;
        req_addr[2] = 32'h40; req_valid[2] = 1'b1;
        check("midrst ready", 32'(req_ready[2]), 32'd1);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        seen = resp_valid[2];
        repeat (2) begin @(posedge clk); #1; seen = seen | resp_valid[2]; end
        rst_n[2] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | resp_valid[2];
            check("midrst ready low", 32'(req_ready[2]), 32'd0);
        end
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        seen = seen | resp_valid[2];
        check("midrst no resp", 32'(seen), 32'd0);
        check("midrst ready after", 32'(req_ready[2]), 32'd1);
        txn(2, "midrst ld", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
